// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: one outstanding word fetch on the IF port,
// results buffered in a prefetch FIFO that decode drains via valid/ready.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] if_addr,
  output logic        if_req,
  input  logic [31:0] if_data,
  input  logic        if_ready,
  input  logic        if_error,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        inst_ready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t           state, state_next;
  logic [31:0]      pc, pending_pc, target;
  logic             discard, halted;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             resp, push, pop, in_req;

  logic [31:0] data_mem  [FIFO_DEPTH];
  logic [31:0] pc_mem    [FIFO_DEPTH];
  logic        fault_mem [FIFO_DEPTH];

  assign resp   = if_ready | if_error;
  assign in_req = (state == ST_REQ);
  assign target = redirect_pc & 32'hFFFF_FFFC;
  // A redirect drops any response arriving with it and overrides a pop.
  assign push   = in_req & resp & ~discard & ~redirect_valid;
  assign pop    = inst_valid & inst_ready & ~redirect_valid;

  assign if_req  = in_req & ~resp;
  assign if_addr = pc;

  assign inst_valid = (count != '0);
  assign inst_data  = inst_valid ? data_mem[rd_ptr]  : '0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr]    : '0;
  assign inst_fault = inst_valid ? fault_mem[rd_ptr] : 1'b0;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (!redirect_valid && (count < DEPTH_C) && !halted) state_next = ST_REQ;
      ST_REQ:  if (resp) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      pending_pc <= '0;
      discard    <= 1'b0;
      halted     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        halted <= 1'b0;
        // if_addr is frozen while a request is pending; park the target instead.
        if (in_req && !resp) begin
          discard    <= 1'b1;
          pending_pc <= target;
        end else begin
          discard <= 1'b0;
          pc      <= target;
        end
      end else begin
        if (in_req && resp && discard) begin
          discard <= 1'b0;
          pc      <= pending_pc;
        end
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          if (if_error) halted <= 1'b1;
          else          pc     <= pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr]  <= if_error ? '0 : if_data;
      pc_mem[wr_ptr]    <= pc;
      fault_mem[wr_ptr] <= if_error;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with fixed expectations,
// then long streams checked against a queue-based fetch model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] if_addr, if_data = '0, redirect_pc = '0;
  logic        if_req, if_ready = 1'b0, if_error = 1'b0, redirect_valid = 1'b0;
  logic        inst_valid, inst_fault, inst_ready = 1'b0;
  logic [31:0] inst_data, inst_pc;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        fault;
  } ent_t;

  ent_t        q[$];
  logic        m_busy, m_drop, m_halt;
  logic [31:0] m_pc, m_pend;
  int unsigned vecs = 0, errs = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .if_addr(if_addr), .if_req(if_req),
    .if_data(if_data), .if_ready(if_ready), .if_error(if_error),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .inst_ready(inst_ready)
  );

  task automatic model_reset;
    m_busy = 1'b0; m_drop = 1'b0; m_halt = 1'b0; m_pc = RST_PC; m_pend = '0;
    q.delete();
  endtask

  // One clock: apply inputs, advance the model across the edge, clear pulses.
  task automatic tick(input bit r, input logic [31:0] tgt, input bit rsp, input bit err, input bit rdy);
    logic [31:0] t, d;
    int unsigned sz;
    t = tgt & 32'hFFFF_FFFC;
    d = err ? 32'h0 : (m_pc ^ KEY);
    redirect_valid = r;
    redirect_pc    = tgt;
    if_error       = rsp & err;
    if_ready       = rsp & (~err | ($urandom_range(0, 1) == 1));
    if_data        = err ? $urandom : (m_pc ^ KEY);
    inst_ready     = rdy;
    @(posedge clk);
    sz = q.size();
    if (rdy && sz != 0 && !r) void'(q.pop_front());
    if (m_busy) begin
      if (rsp) begin
        m_busy = 1'b0;
        if (r) begin
          m_pc = t; m_drop = 1'b0;
        end else if (m_drop) begin
          m_drop = 1'b0; m_pc = m_pend;
        end else begin
          q.push_back('{data: d, pc: m_pc, fault: err});
          if (err) m_halt = 1'b1;
          else     m_pc = m_pc + 32'd4;
        end
      end else if (r) begin
        m_drop = 1'b1; m_pend = t;
      end
    end else begin
      if (r) m_pc = t;
      else if (sz < DEPTH && !m_halt) m_busy = 1'b1;
    end
    if (r) begin
      q.delete(); m_halt = 1'b0;
    end
    #1;
    redirect_valid = 1'b0; if_ready = 1'b0; if_error = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; redirect_valid = 1'b0; if_ready = 1'b0; if_error = 1'b0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset;
    do_reset();
    tick(0, '0, 0, 0, 0);
    tick(0, '0, 1, 0, 0);
    tick(0, '0, 0, 0, 0);
    vecs++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL pre_reset_valid: got %b expected 1", inst_valid); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (if_req !== 1'b0) begin errs++; $display("FAIL reset_if_req: got %b expected 0", if_req); end
    vecs++; if (if_addr !== RST_PC) begin errs++; $display("FAIL reset_if_addr: got %h expected %h", if_addr, RST_PC); end
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    vecs++; if ({inst_data, inst_pc, inst_fault} !== 65'd0) begin errs++; $display("FAIL reset_inst_head: got %h/%h/%b expected 0/0/0", inst_data, inst_pc, inst_fault); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    vecs++; if (if_req !== 1'b0) begin errs++; $display("FAIL release_if_req: got %b expected 0", if_req); end
    tick(0, '0, 0, 0, 0);
    vecs++; if ({if_req, if_addr} !== {1'b1, RST_PC}) begin errs++; $display("FAIL first_req: got %b/%h expected 1/%h", if_req, if_addr, RST_PC); end
  endtask

  task automatic test_stream;
    logic [31:0] exp;
    do_reset();
    tick(0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      exp = RST_PC + 32'(4 * i);
      vecs++; if ({if_req, if_addr} !== {1'b1, exp}) begin errs++; $display("FAIL stream_req: got %b/%h expected 1/%h", if_req, if_addr, exp); end
      tick(0, '0, 1, 0, 1);
      vecs++; if (if_req !== 1'b0) begin errs++; $display("FAIL stream_bubble: got %b expected 0", if_req); end
      vecs++; if ({inst_valid, inst_pc, inst_data, inst_fault} !== {1'b1, exp, exp ^ KEY, 1'b0})
        begin errs++; $display("FAIL stream_head: got %b/%h/%h/%b expected 1/%h/%h/0", inst_valid, inst_pc, inst_data, inst_fault, exp, exp ^ KEY); end
      tick(0, '0, 0, 0, 1);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp;
    do_reset();
    tick(0, '0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      exp = RST_PC + 32'(4 * i);
      vecs++; if ({if_req, if_addr} !== {1'b1, exp}) begin errs++; $display("FAIL bp_req: got %b/%h expected 1/%h", if_req, if_addr, exp); end
      tick(0, '0, 1, 0, 0);
      tick(0, '0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      vecs++; if (if_req !== 1'b0) begin errs++; $display("FAIL bp_full_no_req: got %b expected 0", if_req); end
      vecs++; if (inst_pc !== 32'h100) begin errs++; $display("FAIL bp_head_stable: got %h expected 00000100", inst_pc); end
      tick(0, '0, 0, 0, 0);
    end
    tick(0, '0, 0, 0, 1);
    vecs++; if ({if_req, inst_pc} !== {1'b0, 32'h104}) begin errs++; $display("FAIL bp_pop: got %b/%h expected 0/00000104", if_req, inst_pc); end
    tick(0, '0, 0, 0, 0);
    vecs++; if ({if_req, if_addr} !== {1'b1, 32'h110}) begin errs++; $display("FAIL bp_refill: got %b/%h expected 1/00000110", if_req, if_addr); end
    tick(0, '0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      exp = 32'h108 + 32'(4 * i);
      vecs++; if ({inst_valid, inst_pc, inst_data} !== {1'b1, exp, exp ^ KEY})
        begin errs++; $display("FAIL bp_order: got %b/%h/%h expected 1/%h/%h", inst_valid, inst_pc, inst_data, exp, exp ^ KEY); end
      tick(0, '0, 0, 0, 1);
    end
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL bp_drained: got %b expected 0", inst_valid); end
  endtask

  task automatic test_redirect_inflight;
    do_reset();
    tick(0, '0, 0, 0, 0);
    tick(0, '0, 1, 0, 0);
    tick(0, '0, 0, 0, 0);
    tick(0, '0, 1, 0, 0);
    tick(0, '0, 0, 0, 0);
    vecs++; if ({if_req, if_addr} !== {1'b1, 32'h108}) begin errs++; $display("FAIL rdi_pending: got %b/%h expected 1/00000108", if_req, if_addr); end
    tick(1, 32'h2003, 0, 0, 0);
    vecs++; if ({if_req, if_addr, inst_valid} !== {1'b1, 32'h108, 1'b0}) begin errs++; $display("FAIL rdi_hold: got %b/%h/%b expected 1/00000108/0", if_req, if_addr, inst_valid); end
    tick(0, '0, 1, 0, 0);
    vecs++; if ({if_req, if_addr, inst_valid} !== {1'b0, 32'h2000, 1'b0}) begin errs++; $display("FAIL rdi_drop: got %b/%h/%b expected 0/00002000/0", if_req, if_addr, inst_valid); end
    tick(0, '0, 0, 0, 0);
    vecs++; if ({if_req, if_addr} !== {1'b1, 32'h2000}) begin errs++; $display("FAIL rdi_restart: got %b/%h expected 1/00002000", if_req, if_addr); end
    tick(0, '0, 1, 0, 0);
    vecs++; if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h2000, 32'hA5A5_2000}) begin errs++; $display("FAIL rdi_first_word: got %b/%h/%h expected 1/00002000/a5a52000", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_redirect_resp;
    do_reset();
    tick(0, '0, 0, 0, 0);
    tick(0, '0, 1, 0, 0);
    tick(0, '0, 0, 0, 0);
    tick(1, 32'h3001, 1, 0, 0);
    vecs++; if ({if_req, if_addr, inst_valid} !== {1'b0, 32'h3000, 1'b0}) begin errs++; $display("FAIL rdr_drop: got %b/%h/%b expected 0/00003000/0", if_req, if_addr, inst_valid); end
    tick(0, '0, 0, 0, 0);
    vecs++; if ({if_req, if_addr} !== {1'b1, 32'h3000}) begin errs++; $display("FAIL rdr_restart: got %b/%h expected 1/00003000", if_req, if_addr); end
  endtask

  task automatic test_bus_error;
    do_reset();
    tick(0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, '0, 1, 0, 1);
      tick(0, '0, 0, 0, 1);
    end
    vecs++; if ({if_req, if_addr} !== {1'b1, 32'h10C}) begin errs++; $display("FAIL berr_req: got %b/%h expected 1/0000010c", if_req, if_addr); end
    tick(0, '0, 1, 1, 0);
    vecs++; if ({inst_valid, inst_fault, inst_pc, inst_data} !== {1'b1, 1'b1, 32'h10C, 32'h0})
      begin errs++; $display("FAIL berr_entry: got %b/%b/%h/%h expected 1/1/0000010c/00000000", inst_valid, inst_fault, inst_pc, inst_data); end
    for (int i = 0; i < 4; i++) begin
      vecs++; if ({if_req, if_addr} !== {1'b0, 32'h10C}) begin errs++; $display("FAIL berr_halted: got %b/%h expected 0/0000010c", if_req, if_addr); end
      tick(0, '0, 0, 0, 0);
    end
    tick(1, 32'h300, 0, 0, 0);
    vecs++; if ({if_req, inst_valid} !== 2'b00) begin errs++; $display("FAIL berr_flush: got %b/%b expected 0/0", if_req, inst_valid); end
    tick(0, '0, 0, 0, 0);
    vecs++; if ({if_req, if_addr} !== {1'b1, 32'h300}) begin errs++; $display("FAIL berr_resume: got %b/%h expected 1/00000300", if_req, if_addr); end
  endtask

  // fixed=1: regular push/pop pattern that wraps the pointers many times.
  task automatic test_random_stream(input int n, input bit fixed);
    bit r, rsp, err, rdy;
    logic [31:0] tgt;
    for (int c = 0; c < n; c++) begin
      vecs++; if (if_req !== m_busy) begin errs++; $display("FAIL model_if_req c=%0d: got %b expected %b", c, if_req, m_busy); end
      vecs++; if (if_addr !== m_pc) begin errs++; $display("FAIL model_if_addr c=%0d: got %h expected %h", c, if_addr, m_pc); end
      vecs++; if (inst_valid !== (q.size() != 0)) begin errs++; $display("FAIL model_valid c=%0d: got %b expected %b", c, inst_valid, q.size() != 0); end
      if (q.size() != 0) begin
        vecs++; if ({inst_data, inst_pc, inst_fault} !== q[0])
          begin errs++; $display("FAIL model_head c=%0d: got %h/%h/%b expected %h/%h/%b", c, inst_data, inst_pc, inst_fault, q[0].data, q[0].pc, q[0].fault); end
      end
      if (fixed) begin
        r = 1'b0; tgt = '0; err = 1'b0;
        rsp = m_busy && (c % 2 == 0);
        rdy = (c % 3) != 0;
      end else begin
        r   = $urandom_range(0, 99) < 4;
        tgt = $urandom;
        rsp = m_busy && ($urandom_range(0, 2) == 0);
        err = rsp && ($urandom_range(0, 9) == 0);
        rdy = $urandom_range(0, 1) == 1;
      end
      tick(r, tgt, rsp, err, rdy);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_resp();
    test_bus_error();
    do_reset();
    test_random_stream(80, 1'b1);
    test_random_stream(3000, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
